// File: rtl/lb_pkg.sv
// rtl/lb_pkg.sv - line buffer shared types, FP8 row-storage format and int<->FP8 conversion
package lb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } lb_state_e;

    localparam int FP8_EXP_W    = 4;
    localparam int FP8_MAN_W    = 3;
    localparam int FP8_W        = 1 + FP8_EXP_W + FP8_MAN_W;
    // Exponent code 0 encodes zero; codes 1..15 encode 1.m * 2^(code - FP8_EXP_BIAS).
    // Integer samples never need negative powers, so the bias only reserves code 0.
    localparam int FP8_EXP_BIAS = 1;
    localparam int FP8_MAX_POW  = (1 << FP8_EXP_W) - 1 - FP8_EXP_BIAS;

    // Sign-magnitude conversion, truncating the mantissa, saturating above the top binade.
    function automatic logic [FP8_W-1:0] int_to_fp8(input logic signed [31:0] x);
        logic                 s;
        logic [31:0]          mag;
        int                   p;
        logic [FP8_EXP_W-1:0] e;
        logic [FP8_MAN_W-1:0] m;
        s   = x[31];
        mag = s ? (~x + 32'd1) : x;
        p   = -1;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) p = i;
        end
        if (p < 0) return '0;
        if (p > FP8_MAX_POW) begin
            e = '1;
            m = '1;
        end else begin
            e = FP8_EXP_W'(p + FP8_EXP_BIAS);
            if (p >= FP8_MAN_W) m = FP8_MAN_W'(mag >> (p - FP8_MAN_W));
            else                m = FP8_MAN_W'(mag << (FP8_MAN_W - p));
        end
        return {s, e, m};
    endfunction

    function automatic logic signed [31:0] fp8_to_int(input logic [FP8_W-1:0] f);
        logic [31:0] mag;
        int          p;
        if (f[FP8_W-2 -: FP8_EXP_W] == '0) return '0;
        mag = {{(32 - FP8_MAN_W - 1){1'b0}}, 1'b1, f[FP8_MAN_W-1:0]};
        p   = int'(f[FP8_W-2 -: FP8_EXP_W]) - FP8_EXP_BIAS;
        if (p >= FP8_MAN_W) mag = mag << (p - FP8_MAN_W);
        else                mag = mag >> (FP8_MAN_W - p);
        return f[FP8_W-1] ? -signed'(mag) : signed'(mag);
    endfunction

endpackage

// File: rtl/lb_row_ram.sv
// rtl/lb_row_ram.sv - one stored line: single port, read-first, registered read
module lb_row_ram
    import lb_pkg::*;
#(
    parameter int DEPTH = 224,
    parameter int WIDTH = 20,
    parameter int AW    = 8
) (
    input  logic             fclk,
    input  logic             reset,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array; contents are meaningless until rewritten after a new frame starts
    always_ff @(posedge fclk) begin
        if (en && we) mem_q[addr] <= wdata;
    end

    // Read-first output register; holds while en is low so a stalled column stays put
    always_ff @(posedge fclk or posedge reset) begin
        if (reset)   rdata_q <= '0;
        else if (en) rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/line_buffer_array.sv
// rtl/line_buffer_array.sv - KH-tall column line buffer; define LB_FP8_STORE_EN for FP8 row storage
module line_buffer_array
    import lb_pkg::*;
#(
    parameter int INT_BITS = 20,
    parameter int KH       = 3,
    parameter int LINE_W   = 224
) (
    input  logic                         fclk,
    input  logic                         reset,
    input  logic                         sof,
    input  logic [$clog2(LINE_W+1)-1:0]  line_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INT_BITS-1:0]          in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [KH*INT_BITS-1:0]       out_col,
    output logic                         filled
);

    localparam int ROWS  = KH - 1;
    localparam int LEN_W = $clog2(LINE_W + 1);
    localparam int AW    = $clog2(LINE_W);
    localparam int RP_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
`ifdef LB_FP8_STORE_EN
    localparam int SW    = FP8_W;
`else
    localparam int SW    = INT_BITS;
`endif

    lb_state_e           state_q, state_d;
    logic [AW-1:0]       col_q, col_d;
    logic [RP_W-1:0]     rp_q, rp_d;
    logic [RP_W-1:0]     rd_rp_q, rd_rp_d;
    logic [RP_W-1:0]     fill_q, fill_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                out_valid_q, out_valid_d;
    logic [INT_BITS-1:0] cur_q, cur_d;

    logic                accept, take, wrap;
    logic [AW-1:0]       wr_col;
    logic [RP_W-1:0]     wr_row, eff_fill;
    logic [LEN_W-1:0]    eff_len, clamp_len;
    logic [SW-1:0]       wr_data;
    logic [SW-1:0]       ram_rdata [ROWS];

    // A sof pixel restarts the frame: it is column 0 of line 0 whatever the counters say
    assign accept   = in_valid && in_ready;
    assign take     = accept && (sof || state_q != ST_IDLE);
    assign wr_col   = sof ? '0 : col_q;
    assign wr_row   = sof ? '0 : rp_q;
    assign eff_len  = sof ? clamp_len : len_q;
    assign eff_fill = sof ? '0 : fill_q;
    assign wrap     = (LEN_W'(wr_col) + LEN_W'(1)) == eff_len;

    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign filled    = (state_q == ST_RUN);

    // Line length is clamped to 2..LINE_W before it is latched
    always_comb begin
        clamp_len = line_len;
        if (line_len < LEN_W'(2))           clamp_len = LEN_W'(2);
        else if (line_len > LEN_W'(LINE_W)) clamp_len = LEN_W'(LINE_W);
    end

    // Next-state: frame FSM, column/row pointers and the one-entry output register
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        rp_d        = rp_q;
        rd_rp_d     = rd_rp_q;
        fill_d      = fill_q;
        len_d       = len_q;
        cur_d       = cur_q;
        out_valid_d = out_valid_q;

        if (accept)         out_valid_d = (state_q == ST_RUN) && !sof;
        else if (out_ready) out_valid_d = 1'b0;

        if (take) begin
            cur_d   = in_data;
            rd_rp_d = wr_row;
            len_d   = eff_len;
            fill_d  = eff_fill;
            state_d = sof ? ST_FILL : state_q;
            if (wrap) begin
                col_d = '0;
                rp_d  = (wr_row == RP_W'(ROWS - 1)) ? '0 : wr_row + 1'b1;
                if (state_d == ST_FILL) begin
                    if (eff_fill == RP_W'(ROWS - 1)) begin
                        state_d = ST_RUN;
                        fill_d  = '0;
                    end else begin
                        fill_d  = eff_fill + 1'b1;
                    end
                end
            end else begin
                col_d = wr_col + 1'b1;
                rp_d  = wr_row;
            end
        end
    end

    // State registers
    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            rp_q        <= '0;
            rd_rp_q     <= '0;
            fill_q      <= '0;
            len_q       <= LEN_W'(LINE_W);
            cur_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            rp_q        <= rp_d;
            rd_rp_q     <= rd_rp_d;
            fill_q      <= fill_d;
            len_q       <= len_d;
            cur_q       <= cur_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef LB_FP8_STORE_EN
    assign wr_data = int_to_fp8(32'(signed'(in_data)));
`else
    assign wr_data = in_data;
`endif

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        lb_row_ram #(
            .DEPTH (LINE_W),
            .WIDTH (SW),
            .AW    (AW)
        ) u_row (
            .fclk  (fclk),
            .reset (reset),
            .en    (take),
            .we    (wr_row == RP_W'(r)),
            .addr  (wr_col),
            .wdata (wr_data),
            .rdata (ram_rdata[r])
        );
    end

    // Slice k comes from the row written k lines before the registered pixel's row
    always_comb begin
        int              idx;
        logic [RP_W-1:0] sel;
        idx     = 0;
        sel     = '0;
        out_col = '0;
        out_col[INT_BITS-1:0] = cur_q;
        for (int k = 1; k <= ROWS; k++) begin
            idx = int'(rd_rp_q) - k;
            if (idx < 0) idx = idx + ROWS;
            sel = RP_W'(idx);
`ifdef LB_FP8_STORE_EN
            out_col[k*INT_BITS +: INT_BITS] = INT_BITS'(fp8_to_int(ram_rdata[sel]));
`else
            out_col[k*INT_BITS +: INT_BITS] = ram_rdata[sel];
`endif
        end
    end

endmodule

// File: tb/tb_line_buffer_array.sv
// tb/tb_line_buffer_array.sv - self-checking bench for line_buffer_array with output scoreboard
module tb_line_buffer_array;

    localparam int INT_BITS = 20;
    localparam int KH       = 3;
    localparam int LINE_W   = 224;
    localparam int LEN_W    = $clog2(LINE_W + 1);
`ifdef LB_FP8_STORE_EN
    localparam logic [INT_BITS-1:0] READ_1000 = 20'd960;
`else
    localparam logic [INT_BITS-1:0] READ_1000 = 20'd1000;
`endif

    logic                   fclk      = 1'b0;
    logic                   reset     = 1'b1;
    logic                   sof       = 1'b0;
    logic [LEN_W-1:0]       line_len  = LEN_W'(4);
    logic                   in_valid  = 1'b0;
    logic                   in_ready;
    logic [INT_BITS-1:0]    in_data   = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [KH*INT_BITS-1:0] out_col;
    logic                   filled;

    int errors = 0;
    int checks = 0;

    logic [KH*INT_BITS-1:0] exp_q [$];
    int frame [$];
    int m_state = 0;
    int m_col   = 0;
    int m_line  = 0;
    int m_len   = LINE_W;

    always #5 fclk = ~fclk;

    line_buffer_array #(
        .INT_BITS (INT_BITS),
        .KH       (KH),
        .LINE_W   (LINE_W)
    ) dut (
        .fclk      (fclk),
        .reset     (reset),
        .sof       (sof),
        .line_len  (line_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .filled    (filled)
    );

    function automatic int stored_val(input int v);
`ifdef LB_FP8_STORE_EN
        if (v == 1000) return 960;
`endif
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_col   = 0;
        m_line  = 0;
        frame.delete();
        exp_q.delete();
    endtask

    task automatic model_accept(input int d, input logic s, input int len);
        logic [KH*INT_BITS-1:0] e;
        if (!s && m_state == 0) return;
        if (s) begin
            m_state = 1;
            m_col   = 0;
            m_line  = 0;
            m_len   = (len < 2) ? 2 : ((len > LINE_W) ? LINE_W : len);
            frame.delete();
        end else if (m_state == 2) begin
            e[INT_BITS-1:0] = INT_BITS'(d);
            for (int k = 1; k < KH; k++)
                e[k*INT_BITS +: INT_BITS] = INT_BITS'(stored_val(frame[(m_line - k) * m_len + m_col]));
            exp_q.push_back(e);
        end
        frame.push_back(d);
        m_col++;
        if (m_col == m_len) begin
            m_col = 0;
            m_line++;
            if (m_state == 1 && m_line == KH - 1) m_state = 2;
        end
    endtask

    task automatic send(input int d, input logic s, input int len);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = INT_BITS'(d);
        sof      = s;
        line_len = LEN_W'(len);
        @(negedge fclk);
        while (!in_ready && t < 200) begin
            @(negedge fclk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
        end else begin
            model_accept(d, s, len);
        end
        @(posedge fclk);
        #1;
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    // Output scoreboard: every output transfer is compared with the oldest expected column
    always @(negedge fclk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected out_col=%h required=no output", out_col);
            end else begin
                logic [KH*INT_BITS-1:0] e;
                e = exp_q.pop_front();
                if (out_col !== e) begin
                    errors++;
                    $display("FAIL sb_column out_col=%h required=%h", out_col, e);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge fclk);
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b required=0", out_valid); end
        if (filled !== 1'b0)    begin errors++; $display("FAIL reset_filled got=%0b required=0", filled); end
        if (out_col !== '0)     begin errors++; $display("FAIL reset_out_col got=%h required=0", out_col); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%0b required=1", in_ready); end
        reset = 1'b0;
        @(posedge fclk);
        #1;
    endtask

    task automatic test_ramp();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(i, i == 0, 4);
            checks++;
            if (out_valid !== 1'(i >= 8)) begin
                errors++;
                $display("FAIL ramp_valid pix=%0d got=%0b required=%0b", i, out_valid, i >= 8);
            end
            if (i == 6 || i == 7) begin
                checks++;
                if (filled !== 1'(i == 7)) begin
                    errors++;
                    $display("FAIL ramp_filled pix=%0d got=%0b required=%0b", i, filled, i == 7);
                end
            end
            if (i == 8) begin
                checks++;
                if (out_col !== {20'd0, 20'd4, 20'd8}) begin
                    errors++;
                    $display("FAIL ramp_first_col got=%h required=%h", out_col, {20'd0, 20'd4, 20'd8});
                end
            end
            if (i == 11) begin
                checks++;
                if (out_col !== {20'd3, 20'd7, 20'd11}) begin
                    errors++;
                    $display("FAIL ramp_last_col got=%h required=%h", out_col, {20'd3, 20'd7, 20'd11});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge fclk);
        @(posedge fclk);
        #1;
        out_ready = 1'b0;
        send(12, 1'b0, 4);
        fork
            begin
                send(13, 1'b0, 4);
                send(14, 1'b0, 4);
                send(15, 1'b0, 4);
            end
            begin
                repeat (5) begin
                    @(negedge fclk);
                    checks += 3;
                    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%0b required=0", in_ready); end
                    if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid got=%0b required=1", out_valid); end
                    if (out_col !== {20'd4, 20'd8, 20'd12}) begin
                        errors++;
                        $display("FAIL stall_hold got=%h required=%h", out_col, {20'd4, 20'd8, 20'd12});
                    end
                end
                @(posedge fclk);
                #1;
                out_ready = 1'b1;
            end
        join
    endtask

    task automatic test_sof_restart();
        send(1, 1'b0, 4);
        send(2, 1'b0, 4);
        for (int i = 0; i < 12; i++) begin
            send((i + 3) % 16, i == 0, 4);
            checks++;
            if (out_valid !== 1'(i >= 8)) begin
                errors++;
                $display("FAIL restart_valid pix=%0d got=%0b required=%0b", i, out_valid, i >= 8);
            end
            if (i == 0) begin
                checks++;
                if (filled !== 1'b0) begin errors++; $display("FAIL restart_filled got=%0b required=0", filled); end
            end
        end
        for (int i = 0; i < 3; i++) send(i + 9, 1'b0, 4);
        for (int i = 0; i < 9; i++) begin
            send(15 - i, i == 0, 4);
            checks++;
            if (out_valid !== 1'(i == 8) || filled !== 1'(i >= 7)) begin
                errors++;
                $display("FAIL wrap_sof pix=%0d valid=%0b filled=%0b required=%0b,%0b",
                         i, out_valid, filled, i == 8, i >= 7);
            end
        end
    endtask

    task automatic test_len_clamp();
        for (int i = 0; i < 6; i++) begin
            send(i, i == 0, 1);
            checks++;
            if (out_valid !== 1'(i >= 4)) begin
                errors++;
                $display("FAIL len1_valid pix=%0d got=%0b required=%0b", i, out_valid, i >= 4);
            end
            if (i == 4) begin
                checks++;
                if (out_col !== {20'd0, 20'd2, 20'd4}) begin
                    errors++;
                    $display("FAIL len1_col got=%h required=%h", out_col, {20'd0, 20'd2, 20'd4});
                end
            end
        end
        for (int i = 0; i < 3 * LINE_W + 2; i++) begin
            send(i % 13, i == 0, LINE_W + 5);
            if (i == 2 * LINE_W - 1 || i == 2 * LINE_W) begin
                checks++;
                if (out_valid !== 1'(i == 2 * LINE_W) || filled !== 1'b1) begin
                    errors++;
                    $display("FAIL lenmax_edge pix=%0d valid=%0b filled=%0b required=%0b,1",
                             i, out_valid, filled, i == 2 * LINE_W);
                end
            end
            if (i == 2 * LINE_W) begin
                checks++;
                if (out_col !== {20'd0, 20'd3, 20'd6}) begin
                    errors++;
                    $display("FAIL lenmax_col got=%h required=%h", out_col, {20'd0, 20'd3, 20'd6});
                end
            end
        end
    endtask

    task automatic test_fp8();
        int vals [12];
        vals = '{5, 1000, 1, 2, 3, 4, 6, 7, 1000, 1000, 8, 9};
        for (int i = 0; i < 12; i++) begin
            send(vals[i], i == 0, 4);
            if (i == 8) begin
                checks++;
                if (out_col !== {20'd5, 20'd3, 20'd1000}) begin
                    errors++;
                    $display("FAIL store_small got=%h required=%h", out_col, {20'd5, 20'd3, 20'd1000});
                end
            end
            if (i == 9) begin
                checks++;
                if (out_col !== {READ_1000, 20'd4, 20'd1000}) begin
                    errors++;
                    $display("FAIL store_large got=%h required=%h", out_col, {READ_1000, 20'd4, 20'd1000});
                end
            end
        end
    endtask

    task automatic test_reset_run();
        @(negedge fclk);
        @(posedge fclk);
        #1;
        out_ready = 1'b0;
        send(5, 1'b0, 4);
        @(negedge fclk);
        reset = 1'b1;
        model_reset();
        @(posedge fclk);
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_run_valid got=%0b required=0", out_valid); end
        if (filled !== 1'b0)    begin errors++; $display("FAIL rst_run_filled got=%0b required=0", filled); end
        if (out_col !== '0)     begin errors++; $display("FAIL rst_run_col got=%h required=0", out_col); end
        @(negedge fclk);
        reset     = 1'b0;
        out_ready = 1'b1;
        @(posedge fclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            send(i + 1, 1'b0, 4);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || filled !== 1'b0) begin
                errors++;
                $display("FAIL idle_drop pix=%0d valid=%0b ready=%0b filled=%0b required=0,1,0",
                         i, out_valid, in_ready, filled);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_sof_restart();
        test_len_clamp();
        test_fp8();
        test_reset_run();
        repeat (3) @(posedge fclk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
